// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM write-path constants and FSM state type
package sdram_pkg;

  localparam int SDRAM_BURST_LEN = 8;
  localparam int SDRAM_ADDR_W    = 20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_BURST
  } wr_state_t;

endpackage

// File: rtl/sdram_wr_buffer_if.sv
// rtl/sdram_wr_buffer_if.sv - upstream stream and controller-side signals of the write buffer
interface sdram_wr_buffer_if import sdram_pkg::*; #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = SDRAM_ADDR_W
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              din_valid;
  logic [15:0]       din;
  logic              din_ready;
  logic [15:0]       sdram_data;
  logic [ADDR_W-1:0] sdram_addr;
  logic              write_req;
  logic              fifo_rd_req;
  logic              write_ack;
  logic [LVL_W-1:0]  fill_level;
  logic              overflow;
  logic              underflow;
  logic              burst_err;

  modport master (
    input  din_valid, din, fifo_rd_req, write_ack,
    output din_ready, sdram_data, sdram_addr, write_req, fill_level,
           overflow, underflow, burst_err
  );

  modport slave (
    output din_valid, din, fifo_rd_req, write_ack,
    input  din_ready, sdram_data, sdram_addr, write_req, fill_level,
           overflow, underflow, burst_err
  );
endinterface

// File: rtl/sdram_wr_fifo.sv
// rtl/sdram_wr_fifo.sv - synchronous first-word-fall-through FIFO of 16-bit words
module sdram_wr_fifo import sdram_pkg::*; #(
  parameter int DEPTH = 512
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [15:0]            wdata,
  output logic [15:0]            rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head word is read combinationally so the consumer sees it in the pop cycle.
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/sdram_wr_buffer.sv
// rtl/sdram_wr_buffer.sv - buffers upstream words and issues SDRAM write bursts
module sdram_wr_buffer import sdram_pkg::*; #(
  parameter int          DEPTH      = 512,
  parameter int          BURST_LEN  = SDRAM_BURST_LEN,
  parameter int          ADDR_W     = SDRAM_ADDR_W,
  parameter int unsigned ADDR_LIMIT = 32'd1 << SDRAM_ADDR_W
) (
  input logic               S_CLK,
  input logic               RST_N,
  sdram_wr_buffer_if.master bus
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(ADDR_LIMIT);

  wr_state_t         state, state_nxt;
  logic [LW-1:0]     pop_cnt, pop_cnt_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [ADDR_W:0]   addr_sum;
  logic              write_req_nxt;
  logic              fifo_full, fifo_empty;
  logic              busy, pop_ok, ack;

  assign busy     = (state == ST_REQ) || (state == ST_BURST);
  assign pop_ok   = bus.fifo_rd_req && busy && !fifo_empty;
  assign ack      = bus.write_ack && busy;
  assign addr_sum = {1'b0, addr} + (ADDR_W+1)'(BURST_LEN);

  sdram_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (S_CLK),
    .rst_n (RST_N),
    .push  (bus.din_valid),
    .pop   (pop_ok),
    .wdata (bus.din),
    .rdata (bus.sdram_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (bus.fill_level)
  );

  assign bus.din_ready  = !fifo_full;
  assign bus.sdram_addr = addr;

  always_ff @(posedge S_CLK) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pop_cnt_nxt = pop_cnt;
    addr_nxt    = addr;
    if (pop_ok && pop_cnt != '1) pop_cnt_nxt = pop_cnt + 1'b1;
    case (state)
      ST_IDLE:  if (bus.fill_level >= LW'(BURST_LEN)) state_nxt = ST_REQ;
      ST_REQ:   if (pop_ok) state_nxt = ST_BURST;
      ST_BURST: state_nxt = ST_BURST;
      default:  state_nxt = ST_IDLE;
    endcase
    // The acknowledge closes the burst whatever the pop count reached.
    if (ack) begin
      state_nxt   = ST_IDLE;
      pop_cnt_nxt = '0;
      addr_nxt    = (addr_sum >= LIMIT) ? '0 : addr_sum[ADDR_W-1:0];
    end
    write_req_nxt = (state_nxt == ST_REQ) ||
                    ((state_nxt == ST_BURST) && (pop_cnt_nxt < LW'(BURST_LEN)));
  end

  always_ff @(posedge S_CLK) begin
    if (!RST_N) begin
      pop_cnt       <= '0;
      addr          <= '0;
      bus.write_req <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
      bus.burst_err <= 1'b0;
    end else begin
      pop_cnt       <= pop_cnt_nxt;
      addr          <= addr_nxt;
      bus.write_req <= write_req_nxt;
      bus.overflow  <= bus.overflow  | (bus.din_valid && fifo_full);
      bus.underflow <= bus.underflow | (bus.fifo_rd_req && !pop_ok);
      bus.burst_err <= bus.burst_err | (ack && pop_cnt != LW'(BURST_LEN));
    end
  end
endmodule

// File: tb/tb_sdram_wr_buffer.sv
// tb/tb_sdram_wr_buffer.sv - scoreboard bench for sdram_wr_buffer
module tb_sdram_wr_buffer;
  import sdram_pkg::*;

  logic S_CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 S_CLK = ~S_CLK;

  sdram_wr_buffer_if #(.DEPTH(512), .ADDR_W(20)) bus ();
  sdram_wr_buffer_if #(.DEPTH(512), .ADDR_W(20)) wbus ();

  sdram_wr_buffer #(.DEPTH(512), .BURST_LEN(8), .ADDR_W(20), .ADDR_LIMIT(32'd1 << 20)) u_dut (
    .S_CLK (S_CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  sdram_wr_buffer #(.DEPTH(512), .BURST_LEN(8), .ADDR_W(20), .ADDR_LIMIT(16)) u_wrap (
    .S_CLK (S_CLK),
    .RST_N (RST_N),
    .bus   (wbus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          mcnt  = 0;
  logic [15:0] exp_q [$];
  logic [15:0] wq    [$];

  task automatic drive(input bit v, input logic [15:0] d, input bit rd, input bit ack, input bit pop_acc);
    bus.din_valid   = v;
    bus.din         = d;
    bus.fifo_rd_req = rd;
    bus.write_ack   = ack;
    if (v && mcnt < 512) begin exp_q.push_back(d); mcnt++; end
    if (rd && pop_acc && exp_q.size() > 0) begin void'(exp_q.pop_front()); mcnt--; end
    @(posedge S_CLK); #1;
    bus.din_valid   = 1'b0;
    bus.fifo_rd_req = 1'b0;
    bus.write_ack   = 1'b0;
  endtask

  task automatic tick();
    @(posedge S_CLK); #1;
  endtask

  task automatic apply_reset();
    RST_N = 1'b0;
    drive(0, 16'h0, 0, 0, 0);
    drive(0, 16'h0, 0, 0, 0);
    exp_q.delete();
    wq.delete();
    mcnt  = 0;
    RST_N = 1'b1;
  endtask

  task automatic do_burst(input int n, input logic [19:0] exp_addr);
    int w = 0;
    logic [15:0] e;
    while (bus.write_req !== 1'b1 && w < 20) begin drive(0, 16'h0, 0, 0, 0); w++; end
    n_vec++;
    if (bus.write_req !== 1'b1) begin n_err++; $display("FAIL burst_req_timeout got %b required 1", bus.write_req); end
    n_vec++;
    if (bus.sdram_addr !== exp_addr) begin n_err++; $display("FAIL burst_addr got %0h required %0h", bus.sdram_addr, exp_addr); end
    for (int i = 0; i < n; i++) begin
      e = (exp_q.size() > 0) ? exp_q[0] : 16'hxxxx;
      n_vec++;
      if (bus.sdram_data !== e) begin n_err++; $display("FAIL burst_data[%0d] got %0h required %0h", i, bus.sdram_data, e); end
      drive(0, 16'h0, 1, 0, 1);
    end
    n_vec++;
    if (bus.write_req !== (n < 8)) begin n_err++; $display("FAIL burst_req_after_pops got %b required %b", bus.write_req, (n < 8)); end
    drive(0, 16'h0, 0, 1, 0);
    n_vec++;
    if (bus.sdram_addr !== exp_addr + 20'd8) begin n_err++; $display("FAIL burst_addr_next got %0h required %0h", bus.sdram_addr, exp_addr + 20'd8); end
    n_vec++;
    if (bus.burst_err !== (n != 8)) begin n_err++; $display("FAIL burst_err got %b required %b", bus.burst_err, (n != 8)); end
    n_vec++;
    if (bus.write_req !== 1'b0 || bus.fill_level !== 10'(mcnt)) begin
      n_err++; $display("FAIL burst_post_ack req=%b fill=%0d required req=0 fill=%0d", bus.write_req, bus.fill_level, mcnt);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if (bus.write_req !== 1'b0) begin n_err++; $display("FAIL reset_write_req got %b required 0", bus.write_req); end
    n_vec++;
    if (bus.fill_level !== 10'd0) begin n_err++; $display("FAIL reset_fill got %0d required 0", bus.fill_level); end
    n_vec++;
    if (bus.din_ready !== 1'b1) begin n_err++; $display("FAIL reset_din_ready got %b required 1", bus.din_ready); end
    n_vec++;
    if (bus.sdram_addr !== 20'd0) begin n_err++; $display("FAIL reset_addr got %0h required 0", bus.sdram_addr); end
    n_vec++;
    if ({bus.overflow, bus.underflow, bus.burst_err} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags got %b required 000", {bus.overflow, bus.underflow, bus.burst_err});
    end
  endtask

  task automatic test_single_burst();
    apply_reset();
    for (int i = 0; i < 8; i++) drive(1, 16'(i + 1), 0, 0, 0);
    n_vec++;
    if (bus.write_req !== 1'b0 || bus.fill_level !== 10'd8) begin
      n_err++; $display("FAIL single_fill req=%b fill=%0d required req=0 fill=8", bus.write_req, bus.fill_level);
    end
    drive(0, 16'h0, 0, 0, 0);
    n_vec++;
    if (bus.write_req !== 1'b1) begin n_err++; $display("FAIL single_req_latency got %b required 1", bus.write_req); end
    do_burst(8, 20'd0);
    n_vec++;
    if ({bus.overflow, bus.underflow} !== 2'b00) begin
      n_err++; $display("FAIL single_flags got %b required 00", {bus.overflow, bus.underflow});
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 24; i++) drive(1, 16'h0100 + 16'(i), 0, 0, 0);
    for (int b = 0; b < 3; b++) begin
      do_burst(8, 20'(b * 8));
      if (b < 2) begin
        drive(0, 16'h0, 0, 0, 0);
        n_vec++;
        if (bus.write_req !== 1'b1) begin n_err++; $display("FAIL b2b_one_idle[%0d] got %b required 1", b, bus.write_req); end
      end
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 513; i++) begin
      drive(1, 16'(i), 0, 0, 0);
      if (i == 511) begin
        n_vec++;
        if (bus.din_ready !== 1'b0 || bus.fill_level !== 10'd512 || bus.overflow !== 1'b0) begin
          n_err++; $display("FAIL ovf_full rdy=%b fill=%0d ovf=%b required 0 512 0", bus.din_ready, bus.fill_level, bus.overflow);
        end
      end
    end
    n_vec++;
    if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b required 1", bus.overflow); end
    n_vec++;
    if (bus.fill_level !== 10'(mcnt)) begin n_err++; $display("FAIL ovf_fill got %0d required %0d", bus.fill_level, mcnt); end
    n_vec++;
    if (bus.sdram_data !== exp_q[0]) begin n_err++; $display("FAIL ovf_head got %0h required %0h", bus.sdram_data, exp_q[0]); end
  endtask

  task automatic test_addr_wrap();
    logic [19:0] ea;
    logic [15:0] e;
    int w;
    apply_reset();
    ea = 20'd0;
    for (int i = 0; i < 24; i++) begin
      wbus.din_valid = 1'b1;
      wbus.din       = 16'h0200 + 16'(i);
      wq.push_back(wbus.din);
      tick();
    end
    wbus.din_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      w = 0;
      while (wbus.write_req !== 1'b1 && w < 20) begin tick(); w++; end
      n_vec++;
      if (wbus.write_req !== 1'b1 || wbus.sdram_addr !== ea) begin
        n_err++; $display("FAIL wrap_start[%0d] req=%b addr=%0h required 1 %0h", b, wbus.write_req, wbus.sdram_addr, ea);
      end
      for (int i = 0; i < 8; i++) begin
        e = (wq.size() > 0) ? wq.pop_front() : 16'hxxxx;
        n_vec++;
        if (wbus.sdram_data !== e) begin n_err++; $display("FAIL wrap_data got %0h required %0h", wbus.sdram_data, e); end
        wbus.fifo_rd_req = 1'b1;
        tick();
        wbus.fifo_rd_req = 1'b0;
      end
      wbus.write_ack = 1'b1;
      tick();
      wbus.write_ack = 1'b0;
      ea = (ea + 20'd8 >= 20'd16) ? 20'd0 : ea + 20'd8;
      n_vec++;
      if (wbus.sdram_addr !== ea) begin n_err++; $display("FAIL wrap_addr[%0d] got %0h required %0h", b, wbus.sdram_addr, ea); end
    end
  endtask

  task automatic test_errors();
    apply_reset();
    drive(1, 16'hA5A5, 0, 0, 0);
    drive(0, 16'h0, 1, 0, 0);
    n_vec++;
    if (bus.underflow !== 1'b1) begin n_err++; $display("FAIL underflow_flag got %b required 1", bus.underflow); end
    n_vec++;
    if (bus.fill_level !== 10'd1 || bus.sdram_data !== exp_q[0]) begin
      n_err++; $display("FAIL underflow_ptr fill=%0d head=%0h required 1 %0h", bus.fill_level, bus.sdram_data, exp_q[0]);
    end
    for (int i = 0; i < 7; i++) drive(1, 16'h0400 + 16'(i), 0, 0, 0);
    do_burst(5, 20'd0);
    n_vec++;
    if (bus.fill_level !== 10'd3) begin n_err++; $display("FAIL burst_err_fill got %0d required 3", bus.fill_level); end
  endtask

  task automatic test_reset_mid_burst();
    int w = 0;
    apply_reset();
    for (int i = 0; i < 16; i++) drive(1, 16'h0500 + 16'(i), 0, 0, 0);
    while (bus.write_req !== 1'b1 && w < 20) begin drive(0, 16'h0, 0, 0, 0); w++; end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (bus.sdram_data !== exp_q[0]) begin n_err++; $display("FAIL mid_data[%0d] got %0h required %0h", i, bus.sdram_data, exp_q[0]); end
      drive(0, 16'h0, 1, 0, 1);
    end
    RST_N = 1'b0;
    drive(0, 16'h0, 0, 0, 0);
    n_vec++;
    if (bus.write_req !== 1'b0 || bus.fill_level !== 10'd0 || bus.din_ready !== 1'b1 || bus.sdram_addr !== 20'd0) begin
      n_err++; $display("FAIL mid_reset_state req=%b fill=%0d rdy=%b addr=%0h required 0 0 1 0",
                        bus.write_req, bus.fill_level, bus.din_ready, bus.sdram_addr);
    end
    n_vec++;
    if ({bus.overflow, bus.underflow, bus.burst_err} !== 3'b000) begin
      n_err++; $display("FAIL mid_reset_flags got %b required 000", {bus.overflow, bus.underflow, bus.burst_err});
    end
    RST_N = 1'b1;
    exp_q.delete();
    mcnt = 0;
    for (int i = 0; i < 8; i++) drive(1, 16'h0600 + 16'(i), 0, 0, 0);
    do_burst(8, 20'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.din_valid    = 1'b0;
    bus.din          = 16'h0;
    bus.fifo_rd_req  = 1'b0;
    bus.write_ack    = 1'b0;
    wbus.din_valid   = 1'b0;
    wbus.din         = 16'h0;
    wbus.fifo_rd_req = 1'b0;
    wbus.write_ack   = 1'b0;
    test_reset();
    test_single_burst();
    test_back_to_back();
    test_overflow();
    test_addr_wrap();
    test_errors();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
